// File: rtl/i2c_ov7670_cfg_ctrl_if.sv
// Register-write handshake between the OV7670 config sequencer and the
// SCCB/I2C write engine.
interface i2c_ov7670_cfg_ctrl_if;
  logic       i2c_req;
  logic [7:0] i2c_slave_addr;
  logic [7:0] i2c_reg_addr;
  logic [7:0] i2c_wr_data;
  logic       i2c_done;
  logic       i2c_nack;

  // sequencer side
  modport master (
    output i2c_req, i2c_slave_addr, i2c_reg_addr, i2c_wr_data,
    input  i2c_done, i2c_nack
  );

  // write-engine side
  modport slave (
    input  i2c_req, i2c_slave_addr, i2c_reg_addr, i2c_wr_data,
    output i2c_done, i2c_nack
  );
endinterface

// File: rtl/i2c_ov7670_cfg_ctrl.sv
// OV7670 configuration sequencer: waits out sensor power-up, walks the
// register LUT and issues one SCCB write per entry, retrying failed writes
// and inserting a long settle after a soft-reset write.
module i2c_ov7670_cfg_ctrl #(
  parameter int unsigned LUT_SIZE   = 165,
  parameter logic [7:0]  SLAVE_ADDR = 8'h42,
  parameter logic [23:0] PWR_DLY    = 24'd1_000_000,
  parameter logic [15:0] GAP_DLY    = 16'd500,
  parameter logic [23:0] SRST_DLY   = 24'd100_000,
  parameter logic [15:0] TIMEOUT    = 16'd60_000,
  parameter int unsigned MAX_RETRY  = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_start,
  output logic [7:0]                    lut_index,
  input  logic [15:0]                   lut_data,
  i2c_ov7670_cfg_ctrl_if.master         i2c,
  output logic                          cfg_busy,
  output logic                          cfg_done,
  output logic                          cfg_error
);

  localparam int unsigned RW = $clog2(MAX_RETRY + 2);
  localparam logic [7:0]    LAST_IDX  = 8'(LUT_SIZE - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    PWR_WAIT, LOAD, ISSUE, WAIT_ACK, GAP, DONE, FAIL
  } state_t;

  state_t        state, state_nx;
  logic [23:0]   dcnt;     // power-up count-up, then gap/settle count-down
  logic [15:0]   tcnt;     // cycles spent in WAIT_ACK
  logic          tmo;      // registered timeout hit
  logic [RW-1:0] retry;
  logic [7:0]    reg_q, dat_q;

  logic ack, fail_ev, pwr_end, srst_wr;

  // A completion in the same cycle as the timeout is taken as the result.
  assign ack     = i2c.i2c_done & ~i2c.i2c_nack;
  assign fail_ev = i2c.i2c_done ? i2c.i2c_nack : tmo;
  assign pwr_end = (dcnt == PWR_DLY - 24'd1);
  // COM7 with the reset bit set resets all sensor registers; it needs a long settle.
  assign srst_wr = (reg_q == 8'h12) & dat_q[7];

  assign i2c.i2c_req        = (state == ISSUE);
  assign i2c.i2c_slave_addr = SLAVE_ADDR;
  assign i2c.i2c_reg_addr   = reg_q;
  assign i2c.i2c_wr_data    = dat_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= PWR_WAIT;
    else     state <= state_nx;
  end

  // Next-state decode.
  always_comb begin
    state_nx = state;
    case (state)
      PWR_WAIT: if (pwr_end) state_nx = LOAD;
      LOAD:     state_nx = ISSUE;
      ISSUE:    state_nx = WAIT_ACK;
      WAIT_ACK: begin
        if (ack)          state_nx = GAP;
        else if (fail_ev) state_nx = (retry < RETRY_MAX) ? ISSUE : FAIL;
      end
      GAP:      if (dcnt == 24'd0) state_nx = (lut_index == LAST_IDX) ? DONE : LOAD;
      DONE,
      FAIL:     if (cfg_start) state_nx = PWR_WAIT;
      default:  state_nx = PWR_WAIT;
    endcase
  end

  // Counters, latched write data, LUT index and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      dcnt      <= '0;
      tcnt      <= '0;
      tmo       <= 1'b0;
      retry     <= '0;
      lut_index <= '0;
      reg_q     <= '0;
      dat_q     <= '0;
      cfg_busy  <= 1'b1;
      cfg_done  <= 1'b0;
      cfg_error <= 1'b0;
    end else begin
      case (state)
        PWR_WAIT: dcnt <= pwr_end ? 24'd0 : dcnt + 24'd1;
        LOAD: begin
          reg_q <= lut_data[15:8];
          dat_q <= lut_data[7:0];
        end
        ISSUE: begin
          tcnt <= '0;
          tmo  <= 1'b0;
        end
        WAIT_ACK: begin
          tcnt <= tcnt + 16'd1;
          // Registered compare keeps the counter out of the next-state path.
          tmo  <= (tcnt == TIMEOUT - 16'd1);
          if (ack) begin
            retry <= '0;
            dcnt  <= srst_wr ? SRST_DLY : {8'd0, GAP_DLY};
          end else if (fail_ev && retry < RETRY_MAX) begin
            retry <= retry + RW'(1);
          end
        end
        GAP: begin
          if (dcnt != 24'd0)             dcnt      <= dcnt - 24'd1;
          else if (lut_index != LAST_IDX) lut_index <= lut_index + 8'd1;
        end
        DONE, FAIL: begin
          if (cfg_start) begin
            lut_index <= '0;
            retry     <= '0;
            dcnt      <= '0;
          end
        end
        default: ;
      endcase
      cfg_done  <= (state_nx == DONE);
      cfg_error <= (state_nx == FAIL);
      cfg_busy  <= (state_nx != DONE) && (state_nx != FAIL);
    end
  end

endmodule

// File: tb/tb_i2c_ov7670_cfg_ctrl.sv
// Directed bench for the OV7670 config sequencer: LUT model, write-engine
// model with programmable NACK / silence, request log, expected values
// worked out by hand from the configured delays.
module tb_i2c_ov7670_cfg_ctrl;
  localparam int LAT = 20;   // engine req -> done latency in cycles
  localparam int PD  = 10;
  localparam int GD  = 4;
  localparam int SD  = 100;
  localparam int TO  = 50;

  logic clk, rst, cfg_start;
  logic [7:0]  lut_index;
  logic [15:0] lut_data;
  logic cfg_busy, cfg_done, cfg_error;

  i2c_ov7670_cfg_ctrl_if bus ();

  i2c_ov7670_cfg_ctrl #(
    .LUT_SIZE(165), .SLAVE_ADDR(8'h42), .PWR_DLY(24'(PD)), .GAP_DLY(16'(GD)),
    .SRST_DLY(24'(SD)), .TIMEOUT(16'(TO)), .MAX_RETRY(2)
  ) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .lut_index(lut_index),
    .lut_data(lut_data), .i2c(bus.master), .cfg_busy(cfg_busy),
    .cfg_done(cfg_done), .cfg_error(cfg_error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // scenario knobs
  bit lut0_srst = 1'b0;
  bit silent    = 1'b0;
  int nack_idx  = -1;
  int nack_left = 0;

  function automatic logic [15:0] lut_f(input logic [7:0] i, input bit srst0);
    if (i == 8'd0)   return srst0 ? 16'h1280 : 16'h3a04;
    if (i == 8'd2)   return 16'h1214;
    if (i == 8'd5)   return 16'h1801;
    if (i == 8'd164) return 16'h3b42;
    return {8'h20 + {2'b00, i[5:0]}, i};
  endfunction

  assign lut_data = lut_f(lut_index, lut0_srst);

  // 1-based cycle count since reset release
  int cyc = 0;
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // request log + write-engine model
  logic [15:0] req_rd  [0:511];
  int          req_cyc [0:511];
  int nreq = 0, n_eng_done = 0, eng_cnt = 0;
  bit eng_nack = 1'b0;

  always @(negedge clk) begin
    bus.i2c_done = 1'b0;
    bus.i2c_nack = 1'b0;
    if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) begin
        bus.i2c_done = 1'b1;
        bus.i2c_nack = eng_nack;
        n_eng_done++;
      end
    end
    if (bus.i2c_req === 1'b1) begin
      if (nreq < 512) begin
        req_rd[nreq]  = {bus.i2c_reg_addr, bus.i2c_wr_data};
        req_cyc[nreq] = cyc + 1;
      end
      nreq++;
      if (!silent) begin
        eng_cnt  = LAT;
        eng_nack = (int'(lut_index) == nack_idx) && (nack_left > 0);
        if (eng_nack) nack_left--;
      end
    end
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic chk_rst(input string p);
    chk({p, "_busy"}, cfg_busy, 1);
    chk({p, "_done"}, cfg_done, 0);
    chk({p, "_err"},  cfg_error, 0);
    chk({p, "_idx"},  lut_index, 0);
    chk({p, "_req"},  bus.i2c_req, 0);
    chk({p, "_reg"},  bus.i2c_reg_addr, 0);
    chk({p, "_dat"},  bus.i2c_wr_data, 0);
    chk({p, "_sla"},  bus.i2c_slave_addr, 8'h42);
  endtask

  task automatic do_rst();
    @(negedge clk);
    rst = 1'b1;
    eng_cnt = 0;
    @(negedge clk);
    @(negedge clk);
    rst  = 1'b0;
    nreq = 0;
  endtask

  task automatic wait_end(input string tag);
    int n = 0;
    while (!(cfg_done || cfg_error) && n < 8000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_bound"}, (n < 8000), 1);
  endtask

  task automatic wait_req(input int k, input string tag);
    int n = 0;
    while (nreq < k && n < 8000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_bound"}, (n < 8000), 1);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  initial begin
    int base;
    rst = 1'b1;
    cfg_start = 1'b0;
    repeat (3) @(negedge clk);
    chk_rst("rst");

    // 1: full sequence; a start pulse while busy must not restart it
    rst = 1'b0;
    nreq = 0;
    wait_req(3, "t1_req3");
    pulse_start();
    wait_end("t1");
    chk("t1_nreq",  nreq, 165);
    chk("t1_first", req_rd[0], 16'h3a04);
    chk("t1_cyc0",  req_cyc[0], PD + 2);
    chk("t1_per",   req_cyc[1] - req_cyc[0], LAT + GD + 3);
    chk("t1_perL",  req_cyc[164] - req_cyc[163], LAT + GD + 3);
    chk("t1_last",  req_rd[164], 16'h3b42);
    chk("t1_done",  cfg_done, 1);
    chk("t1_busy",  cfg_busy, 0);
    chk("t1_err",   cfg_error, 0);

    // 2: one NACK on entry 5, retry succeeds
    nack_idx = 5; nack_left = 1;
    do_rst();
    wait_end("t2");
    chk("t2_nreq",  nreq, 166);
    chk("t2_r5",    req_rd[5], 16'h1801);
    chk("t2_r6",    req_rd[6], 16'h1801);
    chk("t2_rper",  req_cyc[6] - req_cyc[5], LAT + 1);
    chk("t2_next",  req_rd[7], lut_f(8'd6, 1'b0));
    chk("t2_done",  cfg_done, 1);
    chk("t2_err",   cfg_error, 0);

    // 3: persistent NACK on entry 2
    nack_idx = 2; nack_left = 99;
    do_rst();
    wait_end("t3");
    chk("t3_nreq",  nreq, 5);
    chk("t3_r2",    req_rd[2], 16'h1214);
    chk("t3_r3",    req_rd[3], 16'h1214);
    chk("t3_r4",    req_rd[4], 16'h1214);
    chk("t3_err",   cfg_error, 1);
    chk("t3_done",  cfg_done, 0);
    chk("t3_busy",  cfg_busy, 0);
    chk("t3_idx",   lut_index, 2);
    repeat (200) @(negedge clk);
    chk("t3_quiet", nreq, 5);
    chk("t3_hold",  cfg_error, 1);

    // 4: silent engine, timeout retries
    nack_idx = -1; nack_left = 0; silent = 1'b1;
    do_rst();
    wait_end("t4");
    chk("t4_nreq",  nreq, 3);
    chk("t4_per1",  req_cyc[1] - req_cyc[0], TO + 2);
    chk("t4_per2",  req_cyc[2] - req_cyc[1], TO + 2);
    chk("t4_err",   cfg_error, 1);
    chk("t4_idx",   lut_index, 0);

    // 5: soft-reset write at entry 0 gets the long settle
    silent = 1'b0; lut0_srst = 1'b1;
    do_rst();
    wait_end("t5");
    chk("t5_r0",    req_rd[0], 16'h1280);
    chk("t5_srst",  req_cyc[1] - req_cyc[0], LAT + SD + 3);
    chk("t5_gap",   req_cyc[2] - req_cyc[1], LAT + GD + 3);
    chk("t5_nreq",  nreq, 165);
    chk("t5_done",  cfg_done, 1);

    // 6: reset mid-write with the engine's done still pending
    lut0_srst = 1'b0;
    do_rst();
    wait_req(41, "t6_e40");
    repeat (15) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_rst("t6_rst");
    rst  = 1'b0;
    nreq = 0;
    base = n_eng_done;
    wait_req(1, "t6_req0");
    chk("t6_late",  n_eng_done - base, 1);
    chk("t6_cyc0",  req_cyc[0], PD + 2);
    chk("t6_first", req_rd[0], 16'h3a04);
    wait_end("t6");
    chk("t6_nreq",  nreq, 165);
    chk("t6_done",  cfg_done, 1);
    pulse_start();
    nreq = 0;
    chk("t6_sbusy", cfg_busy, 1);
    chk("t6_sdone", cfg_done, 0);
    chk("t6_sidx",  lut_index, 0);
    wait_end("t6s");
    chk("t6_snreq", nreq, 165);
    chk("t6_slast", req_rd[164], 16'h3b42);
    chk("t6_fin",   cfg_done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/i2c_ov7670_cfg_ctrl.md
# i2c_ov7670_cfg_ctrl

Sequencer that walks the OV7670 register-configuration lookup table and issues one SCCB/I2C register write per entry to the I2C write engine. Waits out a sensor power-up delay, retries NACKed or timed-out writes, inserts a long settle after a soft-reset write, and flags completion or failure to the capture pipeline. Sits between the config LUT (combinational, index in, `{reg,data}` out) and the I2C write engine.

## Interface
- `LUT_SIZE`, 165: number of valid LUT entries, indices 0..LUT_SIZE-1.
- `SLAVE_ADDR`, 8'h42: SCCB write address of the OV7670.
- `PWR_DLY`, 24'd1_000_000: cycles from reset release or start to the first write.
- `GAP_DLY`, 16'd500: idle cycles between consecutive writes.
- `SRST_DLY`, 24'd100_000: settle cycles after a write to reg 8'h12 with data bit 7 set.
- `TIMEOUT`, 16'd60_000: cycles to wait for `i2c_done` before treating the write as failed.
- `MAX_RETRY`, 2: extra attempts per entry after the first failure.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `cfg_start` in 1: one-cycle pulse; restarts the full sequence from `PWR_DLY`. Ignored while `cfg_busy`.
- `lut_index` out 8: LUT address.
- `lut_data` in 16: `{reg_addr, reg_data}` for `lut_index`, valid combinationally.
- `i2c_req` out 1: one-cycle write request.
- `i2c_slave_addr` out 8: constant `SLAVE_ADDR`.
- `i2c_reg_addr` out 8: register address, stable from `i2c_req` until `i2c_done`.
- `i2c_wr_data` out 8: register data, stable with `i2c_reg_addr`.
- `i2c_done` in 1: one-cycle pulse, write finished.
- `i2c_nack` in 1: qualified by `i2c_done`; 1 = no ACK.
- `cfg_busy` out 1: sequence in progress.
- `cfg_done` out 1: level; all entries written successfully.
- `cfg_error` out 1: level; an entry exhausted its retries.

## Operation
- States: `PWR_WAIT`, `LOAD`, `ISSUE`, `WAIT_ACK`, `GAP`, `DONE`, `FAIL`.
- Reset: enter `PWR_WAIT`. Delay counter = 0, `lut_index` = 0, retry = 0, `i2c_req` = 0, `i2c_reg_addr`/`i2c_wr_data` = 0, `cfg_busy` = 1, `cfg_done` = 0, `cfg_error` = 0. Configuration self-starts after reset.
- `PWR_WAIT`: count to `PWR_DLY`-1, then go to `LOAD`.
- `LOAD`: latch `lut_data[15:8]` into `i2c_reg_addr` and `lut_data[7:0]` into `i2c_wr_data`. Then go to `ISSUE`.
- `ISSUE`: assert `i2c_req` for exactly one cycle. Clear the timeout counter. Then go to `WAIT_ACK`.
- `WAIT_ACK`:
  - On `i2c_done` with `i2c_nack`=0: clear retry. Load the gap counter with `SRST_DLY` if reg = 8'h12 and data[7] = 1, else `GAP_DLY`. Go to `GAP`.
  - On `i2c_done` with `i2c_nack`=1, or when the timeout counter reaches `TIMEOUT`-1: if retry < `MAX_RETRY`, increment retry and go to `ISSUE` (same latched data). Otherwise go to `FAIL`.
- `GAP`: count down. At zero:
  - If `lut_index` = `LUT_SIZE`-1, go to `DONE`.
  - Otherwise increment `lut_index` and go to `LOAD`.
- `DONE`: `cfg_done`=1, `cfg_busy`=0.
- `FAIL`: `cfg_error`=1, `cfg_busy`=0. `lut_index` holds the failing entry.
- `cfg_start` in `DONE` or `FAIL`: clear `cfg_done`/`cfg_error`, set `cfg_busy`, `lut_index` = 0, retry = 0, enter `PWR_WAIT`.
- `i2c_done` outside `WAIT_ACK` is ignored.
- `lut_index` width is 8 bits; `LUT_SIZE` ≤ 256. No wrap past `LUT_SIZE`-1.

## Timing
- `lut_index` changes on the edge entering `LOAD`. `lut_data` is sampled on the next edge (one-cycle LUT settle).
- First `i2c_req` is asserted `PWR_DLY`+2 cycles after reset deasserts.
- Writes issue once per (engine latency + `GAP_DLY` + 3) cycles.
- `i2c_done` and timeout in the same cycle: `i2c_done` wins.
- `rst` asserted in any state, including mid-write: return to reset values on the next edge. The engine is not aborted; its pending `i2c_done` arrives in `PWR_WAIT` and is ignored.
- `cfg_done`/`cfg_error` set on the edge entering `DONE`/`FAIL`. They are mutually exclusive.

## Test plan
1. Normal sequence. `PWR_DLY`=10, `GAP_DLY`=4, `LUT_SIZE`=165, engine ACKs after 20 cycles.
   - Expect 165 `i2c_req` pulses, first carrying reg 8'h3a / data 8'h04, last carrying 8'h3b / 8'h42.
   - First `i2c_req` at cycle 12.
   - Then `cfg_done`=1, `cfg_busy`=0.
2. Single NACK on entry 5, ACK on retry.
   - Expect a second `i2c_req` with identical reg/data (8'h18 / 8'h01).
   - Sequence then continues; `cfg_done`=1, `cfg_error`=0.
3. Persistent NACK on entry 2, `MAX_RETRY`=2.
   - Expect exactly 3 requests for 8'h12 / 8'h14.
   - Then `cfg_error`=1, `lut_index`=2, no further requests.
4. Engine silent, `TIMEOUT`=50.
   - Expect a retry every 52 cycles, then `FAIL` after 3 attempts.
5. Soft-reset entry. LUT entry 0 is 8'h12 / 8'h80, `SRST_DLY`=100.
   - Expect the next `i2c_req` ≥ 100 cycles after `i2c_done`; other gaps remain `GAP_DLY`.
6. `rst` pulsed during `WAIT_ACK` of entry 40, with a late `i2c_done` arriving afterwards.
   - Expect all outputs at reset values and `lut_index`=0.
   - The late `i2c_done` is ignored; the sequence restarts and completes.
   - After `DONE`, `cfg_start` reruns the full 165 writes.
